video_timing_tracker: RTL and testbench

VIDEO_TIMING_TRACKER -- requirements
Module: video_timing_tracker

---
 rtl/video_timing_tracker.sv | 165 ++++++++++++++++
 tb/tb_video_timing_tracker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_tracker.sv
// Video timing tracker: synchronizes hs_n/vs_n/blank_n, measures line and frame
// lengths, produces pixel coordinates and a SEARCH/ACQUIRE/LOCKED lock monitor.
module video_timing_tracker #(
    parameter int H_CNT_W = 11,
    parameter int V_CNT_W = 10,
    parameter int X_W     = 10
) (
    input  logic               clk_vga,
    input  logic               rst,
    input  logic               hs_n,
    input  logic               vs_n,
    input  logic               blank_n,
    output logic               active,
    output logic [X_W-1:0]     pixel_x,
    output logic [V_CNT_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic [H_CNT_W-1:0] h_total_meas,
    output logic [V_CNT_W-1:0] v_total_meas,
    output logic               locked,
    output logic               timing_error
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [H_CNT_W-1:0] H_MAX = '1;

    // Per input: [0] = s1, [1] = s2, [2] = edge-detect delay flop.
    logic [2:0]         r_hs_sr, r_vs_sr, r_bl_sr;
    logic [H_CNT_W-1:0] r_h_cnt;
    logic [V_CNT_W-1:0] r_l_cnt;

    state_t             r_state, w_state_nxt;
    logic [H_CNT_W-1:0] r_ref_h, w_ref_h_nxt;
    logic [V_CNT_W-1:0] r_ref_v, w_ref_v_nxt;
    logic               r_ref_h_valid, w_ref_h_valid_nxt;
    logic               r_mismatch, w_mismatch_nxt;
    logic               w_err;

    logic               w_hs_fall, w_vs_fall, w_bl_fall, w_bl;
    logic               w_wdog, w_h_bad;
    logic [H_CNT_W-1:0] w_h_meas;
    logic [V_CNT_W-1:0] w_v_meas;

    assign w_hs_fall = r_hs_sr[2] & ~r_hs_sr[1];
    assign w_vs_fall = r_vs_sr[2] & ~r_vs_sr[1];
    assign w_bl_fall = r_bl_sr[2] & ~r_bl_sr[1];
    assign w_bl      = r_bl_sr[1];
    assign w_h_meas  = r_h_cnt + H_CNT_W'(1);
    assign w_v_meas  = r_l_cnt + V_CNT_W'(w_hs_fall);
    assign w_wdog    = (r_h_cnt == H_MAX);
    assign w_h_bad   = w_hs_fall && (w_h_meas != r_ref_h);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_hs_sr      <= '1;
            r_vs_sr      <= '1;
            r_bl_sr      <= '0;
            r_h_cnt      <= '0;
            r_l_cnt      <= '0;
            active       <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else begin
            r_hs_sr     <= {r_hs_sr[1:0], hs_n};
            r_vs_sr     <= {r_vs_sr[1:0], vs_n};
            r_bl_sr     <= {r_bl_sr[1:0], blank_n};
            line_start  <= w_hs_fall;
            frame_start <= w_vs_fall;
            active      <= w_bl;

            if (w_hs_fall) begin
                r_h_cnt      <= '0;
                h_total_meas <= w_h_meas;
            end else if (!w_wdog) begin
                r_h_cnt <= w_h_meas;
            end

            if (w_vs_fall) begin
                v_total_meas <= w_v_meas;
                r_l_cnt      <= '0;
            end else if (w_hs_fall) begin
                r_l_cnt <= r_l_cnt + V_CNT_W'(1);
            end

            if (w_bl && active) pixel_x <= pixel_x + X_W'(1);
            else                pixel_x <= '0;

            if (w_vs_fall)      pixel_y <= '0;
            else if (w_bl_fall) pixel_y <= pixel_y + V_CNT_W'(1);
        end
    end

    // NOTE: every always_comb target gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_ref_h_nxt       = r_ref_h;
        w_ref_v_nxt       = r_ref_v;
        w_ref_h_valid_nxt = r_ref_h_valid;
        w_mismatch_nxt    = r_mismatch;
        w_err             = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vs_fall) begin
                    w_state_nxt       = ACQUIRE;
                    w_ref_h_valid_nxt = 1'b0;
                    w_mismatch_nxt    = 1'b0;
                end
            end
            ACQUIRE: begin
                if (w_wdog) begin
                    w_state_nxt = SEARCH;
                end else if (w_vs_fall) begin
                    // A line ending on the vs fall is judged before the frame verdict.
                    if (r_ref_h_valid && !r_mismatch && !w_h_bad) begin
                        w_state_nxt = LOCKED;
                        w_ref_v_nxt = w_v_meas;
                    end
                    w_ref_h_valid_nxt = 1'b0;
                    w_mismatch_nxt    = 1'b0;
                end else if (w_hs_fall) begin
                    if (!r_ref_h_valid) begin
                        w_ref_h_nxt       = w_h_meas;
                        w_ref_h_valid_nxt = 1'b1;
                    end else if (w_h_bad) begin
                        w_mismatch_nxt = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (w_h_bad || (w_vs_fall && (w_v_meas != r_ref_v)) || w_wdog) begin
                    w_state_nxt = SEARCH;
                    w_err       = 1'b1;
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            r_state       <= SEARCH;
            r_ref_h       <= '0;
            r_ref_v       <= '0;
            r_ref_h_valid <= 1'b0;
            r_mismatch    <= 1'b0;
            locked        <= 1'b0;
            timing_error  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ref_h       <= w_ref_h_nxt;
            r_ref_v       <= w_ref_v_nxt;
            r_ref_h_valid <= w_ref_h_valid_nxt;
            r_mismatch    <= w_mismatch_nxt;
            locked        <= (w_state_nxt == LOCKED);
            timing_error  <= w_err;
        end
    end

endmodule

// File: tb/tb_video_timing_tracker.sv
// Directed bench for video_timing_tracker using a reduced video mode
// (40 clocks x 12 lines, sync 4 clocks / 2 lines, visible h 10..33, v 3..10).
module tb_video_timing_tracker;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;
    localparam int X_W     = 10;
    localparam int H_TOT   = 40;
    localparam int V_TOT   = 12;
    localparam int HS_W    = 4;
    localparam int HA0     = 10;
    localparam int HA1     = 34;
    localparam int VA0     = 3;
    localparam int VA1     = 11;

    logic               clk_vga = 1'b0;
    logic               rst     = 1'b1;
    logic               hs_n    = 1'b1;
    logic               vs_n    = 1'b1;
    logic               blank_n = 1'b0;
    logic               active, line_start, frame_start, locked, timing_error;
    logic [X_W-1:0]     pixel_x;
    logic [V_CNT_W-1:0] pixel_y;
    logic [H_CNT_W-1:0] h_total_meas;
    logic [V_CNT_W-1:0] v_total_meas;

    video_timing_tracker #(.H_CNT_W(H_CNT_W), .V_CNT_W(V_CNT_W), .X_W(X_W)) dut (
        .clk_vga     (clk_vga),
        .rst         (rst),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .blank_n     (blank_n),
        .active      (active),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start),
        .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas),
        .locked      (locked),
        .timing_error(timing_error)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        bit act;
        int px;
        int py;
        bit ls;
        bit fs;
    } exp_t;

    exp_t pipe [4];
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   tick_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   act_bad = 0, px_bad = 0, py_bad = 0, ls_bad = 0, fs_bad = 0;
    int   act_cnt = 0, px_max = 0;
    int   err_cnt = 0, err_hi = 0, err_cyc = -1, lock_rise_cyc = -1;
    int   h_at_err = 0, v_at_err = 0;
    bit   prev_locked = 1'b0, prev_te = 1'b0;

    always @(posedge clk_vga) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    // One pixel clock of stimulus; expected outputs ride a 4-deep pipe (3-edge latency).
    task automatic tick(input logic hs, input logic vs, input logic bl, input int col, input int row);
        @(posedge clk_vga);
        #1;
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0].act = bl;
        pipe[0].px  = bl ? col - HA0 : 0;
        pipe[0].py  = row - VA0;
        pipe[0].ls  = hs_n & ~hs;
        pipe[0].fs  = vs_n & ~vs;
        hs_n        = hs;
        vs_n        = vs;
        blank_n     = bl;
        tick_cyc    = cyc;
    endtask

    task automatic line(input int len, input int row, input bit vsl, output int start);
        bit vis;
        vis   = (row >= VA0) && (row < VA1);
        start = -1;
        for (int c = 0; c < len; c++) begin
            tick(c >= HS_W, !vsl, vis && (c >= HA0) && (c < HA1), c, row);
            if (c == 0) start = tick_cyc;
        end
    endtask

    task automatic frame(input int nlines, input int long_row, input int long_len,
                         output int vs_start, output int mark);
        int s;
        vs_start = -1;
        mark     = -1;
        for (int l = 0; l < nlines; l++) begin
            line((l == long_row) ? long_len : H_TOT, l, l < 2, s);
            if (l == 0) vs_start = s;
            if (l == long_row) mark = s;
        end
    endtask

    always @(negedge clk_vga) begin
        if (chk_en) begin
            if (active !== pipe[3].act) act_bad++;
            if (int'(pixel_x) != pipe[3].px) px_bad++;
            if (pipe[3].act && (int'(pixel_y) != pipe[3].py)) py_bad++;
            if (line_start !== pipe[3].ls) ls_bad++;
            if (frame_start !== pipe[3].fs) fs_bad++;
        end
        if (active) begin
            act_cnt++;
            if (int'(pixel_x) > px_max) px_max = int'(pixel_x);
        end
        if (locked && !prev_locked) lock_rise_cyc = cyc;
        if (timing_error) begin
            err_hi++;
            if (!prev_te) begin
                err_cnt++;
                err_cyc  = cyc;
                h_at_err = int'(h_total_meas);
                v_at_err = int'(v_total_meas);
            end
        end
        prev_locked = locked;
        prev_te     = timing_error;
    end

    initial begin
        int vs0, mk, e0, h0, a0;
        for (int i = 0; i < 4; i++) pipe[i] = '{act: 1'b0, px: 0, py: 0, ls: 1'b0, fs: 1'b0};

        repeat (3) @(posedge clk_vga);
        #1;
        check("rst_active", active, 0);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_pixel_y", pixel_y, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_h_total", h_total_meas, 0);
        check("rst_v_total", v_total_meas, 0);
        check("rst_locked", locked, 0);
        check("rst_timing_error", timing_error, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 0, 0);
        chk_en = 1'b1;

        // First vs fall: SEARCH -> ACQUIRE.
        frame(V_TOT, -1, 0, vs0, mk);
        check("acq_locked", locked, 0);
        check("acq_h_total", h_total_meas, H_TOT);

        // Second vs fall: ACQUIRE -> LOCKED.
        a0 = act_cnt;
        e0 = err_cnt;
        frame(V_TOT, -1, 0, vs0, mk);
        check("lock_latency", lock_rise_cyc - vs0, 3);
        check("lock_locked", locked, 1);
        check("lock_v_total", v_total_meas, V_TOT);
        check("frame_active_cycles", act_cnt - a0, (HA1 - HA0) * (VA1 - VA0));
        check("clean_no_error", err_cnt - e0, 0);

        // Line 5 stretched by one clock while locked.
        e0 = err_cnt;
        h0 = err_hi;
        frame(V_TOT, 5, H_TOT + 1, vs0, mk);
        check("stretch_err_pulses", err_cnt - e0, 1);
        check("stretch_err_width", err_hi - h0, 1);
        check("stretch_err_time", err_cyc - mk, H_TOT + 1 + 3);
        check("stretch_h_meas", h_at_err, H_TOT + 1);
        check("stretch_unlocked", locked, 0);
        frame(V_TOT, -1, 0, vs0, mk);
        check("relock_acquire", locked, 0);
        frame(V_TOT, -1, 0, vs0, mk);
        check("relock_latency", lock_rise_cyc - vs0, 3);
        check("relock_locked", locked, 1);

        // hs_n held high 2100 clocks while locked: watchdog at h_cnt == 2047.
        e0 = err_cnt;
        h0 = err_hi;
        frame(V_TOT, 4, HS_W + 2100, vs0, mk);
        check("wdog_err_pulses", err_cnt - e0, 1);
        check("wdog_err_width", err_hi - h0, 1);
        check("wdog_err_time", err_cyc - mk, 3 + 2048);
        check("wdog_unlocked", locked, 0);

        // Same long line while acquiring: drop to SEARCH silently.
        e0 = err_cnt;
        frame(V_TOT, 4, HS_W + 2100, vs0, mk);
        check("acq_wdog_silent", err_cnt - e0, 0);
        frame(V_TOT, -1, 0, vs0, mk);
        check("wdog_reacquire", locked, 0);
        frame(V_TOT, -1, 0, vs0, mk);
        check("wdog_relocked", locked, 1);

        // One frame of V_TOT-1 lines; error fires on the following vs fall.
        frame(V_TOT - 1, -1, 0, vs0, mk);
        check("short_frame_pending", locked, 1);
        e0 = err_cnt;
        h0 = err_hi;
        frame(V_TOT, -1, 0, vs0, mk);
        check("short_err_pulses", err_cnt - e0, 1);
        check("short_err_width", err_hi - h0, 1);
        check("short_err_time", err_cyc - vs0, 3);
        check("short_v_meas", v_at_err, V_TOT - 1);
        check("short_unlocked", locked, 0);
        frame(V_TOT, -1, 0, vs0, mk);
        frame(V_TOT, -1, 0, vs0, mk);
        check("pre_rst_locked", locked, 1);

        // Asynchronous reset in the middle of a visible line.
        chk_en = 1'b0;
        for (int l = 0; l < V_TOT; l++) begin
            for (int c = 0; c < H_TOT; c++) begin
                tick(c >= HS_W, l >= 2, (l >= VA0) && (l < VA1) && (c >= HA0) && (c < HA1), c, l);
                if (l == 6 && c == 20) begin
                    check("pre_rst_active", active, 1);
                    #2 rst = 1'b1;
                    #1;
                    check("mid_rst_locked", locked, 0);
                    check("mid_rst_active", active, 0);
                    check("mid_rst_pixel_x", pixel_x, 0);
                    check("mid_rst_pixel_y", pixel_y, 0);
                    check("mid_rst_h_total", h_total_meas, 0);
                    check("mid_rst_v_total", v_total_meas, 0);
                end
                if (l == 7 && c == 0) rst = 1'b0;
            end
        end
        chk_en = 1'b1;
        frame(V_TOT, -1, 0, vs0, mk);
        check("post_rst_acquire", locked, 0);
        frame(V_TOT, -1, 0, vs0, mk);
        check("post_rst_latency", lock_rise_cyc - vs0, 3);
        check("post_rst_locked", locked, 1);

        check("active_cycle_errors", act_bad, 0);
        check("pixel_x_errors", px_bad, 0);
        check("pixel_y_errors", py_bad, 0);
        check("line_start_errors", ls_bad, 0);
        check("frame_start_errors", fs_bad, 0);
        check("pixel_x_max", px_max, HA1 - HA0 - 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
